// File: rtl/expr_eval.sv
// Streaming checker and evaluator for ASCII expressions of decimal numbers joined by + - *.
// Tracks syntax one character per accepted clock and keeps a running WIDTH-bit value.
module expr_eval #(
  parameter int unsigned WIDTH       = 16,
  parameter bit          MULTI_DIGIT = 1'b1,
  parameter bit          SKIP_SPACE  = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             out,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {EMPTY, NUM, OP, ERR} state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] sum, sumNext;
  logic [WIDTH-1:0] term, termNext;
  logic [WIDTH-1:0] num, numNext;
  logic [WIDTH-1:0] resultNext;
  logic             neg, negNext;

  logic             isDigit, isOp, isSpace;
  logic [WIDTH-1:0] digitVal, numAcc, product, resultAcc;

  assign isDigit  = (in >= 8'h30) && (in <= 8'h39);
  assign isOp     = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A);
  assign isSpace  = SKIP_SPACE && (in == 8'h20);
  assign digitVal = WIDTH'(in[3:0]);
  assign numAcc   = num * WIDTH'(10) + digitVal;
  assign product  = term * num;
  // Value of the expression as if it ended right after this digit.
  assign resultAcc = neg ? sum - term * numAcc : sum + term * numAcc;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= EMPTY;
      sum    <= '0;
      term   <= WIDTH'(1);
      num    <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      state  <= stateNext;
      sum    <= sumNext;
      term   <= termNext;
      num    <= numNext;
      neg    <= negNext;
      result <= resultNext;
    end
  end

  always_comb begin
    stateNext  = state;
    sumNext    = sum;
    termNext   = term;
    numNext    = num;
    negNext    = neg;
    resultNext = result;
    if (in_valid && !isSpace) begin
      case (state)
        EMPTY, OP: begin
          if (isDigit) begin
            stateNext  = NUM;
            numNext    = numAcc;
            resultNext = resultAcc;
          end else begin
            stateNext = ERR;
          end
        end
        NUM: begin
          if (isDigit) begin
            if (MULTI_DIGIT) begin
              numNext    = numAcc;
              resultNext = resultAcc;
            end else begin
              stateNext = ERR;
            end
          end else if (isOp) begin
            stateNext = OP;
            numNext   = '0;
            if (in == 8'h2A) begin
              termNext = product;
            end else begin
              // Close the pending term into the sum and start a fresh one.
              sumNext  = neg ? sum - product : sum + product;
              termNext = WIDTH'(1);
              negNext  = (in == 8'h2D);
            end
          end else begin
            stateNext = ERR;
          end
        end
        default: stateNext = ERR;
      endcase
    end
  end

  assign out = (state == NUM);
  assign err = (state == ERR);

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: four parameterisations share one byte stream,
// expectations are queued at issue time and checked by a monitor after each accepted char.
module tb_expr_eval;

  localparam int DA = 0;
  localparam int DB = 1;
  localparam int DC = 2;
  localparam int DD = 3;

  typedef struct {
    int          sel;
    int          testId;
    int          step;
    logic        expOut;
    logic        expErr;
    logic [15:0] expRes;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        inValid;
  logic [7:0]  inChar;

  logic        outA, errA, outB, errB, outC, errC, outD, errD;
  logic [15:0] resA, resB;
  logic [7:0]  resC, resD;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   curTest = 0;
  int   stepCnt = 0;

  always #5 clk = ~clk;

  expr_eval #(.WIDTH(16), .MULTI_DIGIT(1'b1), .SKIP_SPACE(1'b1)) dutA (
    .clk(clk), .clr(clr), .in(inChar), .in_valid(inValid),
    .out(outA), .err(errA), .result(resA));

  expr_eval #(.WIDTH(16), .MULTI_DIGIT(1'b0), .SKIP_SPACE(1'b1)) dutB (
    .clk(clk), .clr(clr), .in(inChar), .in_valid(inValid),
    .out(outB), .err(errB), .result(resB));

  expr_eval #(.WIDTH(8), .MULTI_DIGIT(1'b1), .SKIP_SPACE(1'b1)) dutC (
    .clk(clk), .clr(clr), .in(inChar), .in_valid(inValid),
    .out(outC), .err(errC), .result(resC));

  expr_eval #(.WIDTH(8), .MULTI_DIGIT(1'b1), .SKIP_SPACE(1'b0)) dutD (
    .clk(clk), .clr(clr), .in(inChar), .in_valid(inValid),
    .out(outD), .err(errD), .result(resD));

  task automatic checkOutput(input string name, input int sel, input logic eo,
                             input logic ee, input logic [15:0] er);
    logic        ao, ae;
    logic [15:0] ar;
    case (sel)
      DA:      begin ao = outA; ae = errA; ar = resA; end
      DB:      begin ao = outB; ae = errB; ar = resB; end
      DC:      begin ao = outC; ae = errC; ar = {8'h00, resC}; end
      default: begin ao = outD; ae = errD; ar = {8'h00, resD}; end
    endcase
    total++;
    if (ao !== eo) begin
      bad++;
      $display("[TB] FAIL %s dut%0d out: got %b want %b", name, sel, ao, eo);
    end
    total++;
    if (ae !== ee) begin
      bad++;
      $display("[TB] FAIL %s dut%0d err: got %b want %b", name, sel, ae, ee);
    end
    total++;
    if (ar !== er) begin
      bad++;
      $display("[TB] FAIL %s dut%0d result: got %h want %h", name, sel, ar, er);
    end
  endtask

  // Queue the expectation, then present the char for the next rising edge.
  task automatic applyStimulus(input int sel, input logic [7:0] ch, input logic eo,
                               input logic ee, input logic [15:0] er);
    exp_t e;
    stepCnt++;
    e.sel = sel; e.testId = curTest; e.step = stepCnt;
    e.expOut = eo; e.expErr = ee; e.expRes = er;
    sb.push_back(e);
    @(negedge clk);
    inChar  = ch;
    inValid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inValid = 1'b0;
    end
  endtask

  task automatic doReset(input int testId);
    @(negedge clk);
    inValid = 1'b0;
    clr     = 1'b1;
    curTest = testId;
    stepCnt = 0;
    #2;
    checkOutput("reset", DA, 1'b0, 1'b0, 16'd0);
    checkOutput("reset", DB, 1'b0, 1'b0, 16'd0);
    checkOutput("reset", DC, 1'b0, 1'b0, 16'd0);
    checkOutput("reset", DD, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Monitor: every accepted char retires one scoreboard entry shortly after the edge.
  always @(posedge clk) begin
    if (inValid && !clr) begin
      #2;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sbEmpty: got no expectation want one queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput($sformatf("t%0d.%0d", e.testId, e.step), e.sel, e.expOut, e.expErr, e.expRes);
      end
    end
  end

  initial begin
    string tail;
    clr     = 1'b1;
    inValid = 1'b0;
    inChar  = 8'h00;

    // 1+2*3 on consecutive cycles
    doReset(1);
    applyStimulus(DA, "1", 1'b1, 1'b0, 16'd1);
    applyStimulus(DA, "+", 1'b0, 1'b0, 16'd1);
    applyStimulus(DA, "2", 1'b1, 1'b0, 16'd3);
    applyStimulus(DA, "*", 1'b0, 1'b0, 16'd3);
    applyStimulus(DA, "3", 1'b1, 1'b0, 16'd7);
    idle(2);

    // 12*3-4 with an in_valid gap after '*'
    doReset(2);
    applyStimulus(DA, "1", 1'b1, 1'b0, 16'd1);
    applyStimulus(DA, "2", 1'b1, 1'b0, 16'd12);
    applyStimulus(DA, "*", 1'b0, 1'b0, 16'd12);
    @(negedge clk);
    inValid = 1'b0;
    inChar  = "9";
    repeat (2) @(negedge clk);
    checkOutput("gap", DA, 1'b0, 1'b0, 16'd12);
    applyStimulus(DA, "3", 1'b1, 1'b0, 16'd36);
    applyStimulus(DA, "-", 1'b0, 1'b0, 16'd36);
    applyStimulus(DA, "4", 1'b1, 1'b0, 16'd32);
    idle(2);

    // 1+*3 then ten more chars: sticky error, frozen result
    doReset(3);
    applyStimulus(DA, "1", 1'b1, 1'b0, 16'd1);
    applyStimulus(DA, "+", 1'b0, 1'b0, 16'd1);
    applyStimulus(DA, "*", 1'b0, 1'b1, 16'd1);
    applyStimulus(DA, "3", 1'b0, 1'b1, 16'd1);
    tail = "5+6*7-8901";
    for (int i = 0; i < tail.len(); i++)
      applyStimulus(DA, tail[i], 1'b0, 1'b1, 16'd1);
    idle(2);

    // Legacy single-digit mode versus multi-digit
    doReset(4);
    applyStimulus(DB, "1", 1'b1, 1'b0, 16'd1);
    applyStimulus(DB, "2", 1'b0, 1'b1, 16'd1);
    idle(2);
    doReset(5);
    applyStimulus(DA, "1", 1'b1, 1'b0, 16'd1);
    applyStimulus(DA, "2", 1'b1, 1'b0, 16'd12);
    idle(2);

    // Asynchronous clear between edges, then a fresh expression
    doReset(6);
    applyStimulus(DA, "1", 1'b1, 1'b0, 16'd1);
    applyStimulus(DA, "+", 1'b0, 1'b0, 16'd1);
    applyStimulus(DA, "2", 1'b1, 1'b0, 16'd3);
    @(negedge clk);
    inValid = 1'b0;
    #1 clr = 1'b1;
    #1 checkOutput("clrAsync", DA, 1'b0, 1'b0, 16'd0);
    #1 clr = 1'b0;
    applyStimulus(DA, "5", 1'b1, 1'b0, 16'd5);
    idle(1);

    // clr and in_valid together: char discarded
    @(negedge clk);
    inChar  = "9";
    inValid = 1'b1;
    clr     = 1'b1;
    @(negedge clk);
    clr     = 1'b0;
    inValid = 1'b0;
    checkOutput("clrWins", DA, 1'b0, 1'b0, 16'd0);
    applyStimulus(DA, "3", 1'b1, 1'b0, 16'd3);
    @(negedge clk);
    inValid = 1'b0;
    inChar  = "*";
    repeat (2) @(negedge clk);
    checkOutput("idleGarbage", DA, 1'b1, 1'b0, 16'd3);

    // MSB-set byte and leading minus are errors
    doReset(7);
    applyStimulus(DA, 8'hB1, 1'b0, 1'b1, 16'd0);
    idle(1);
    doReset(8);
    applyStimulus(DA, "-", 1'b0, 1'b1, 16'd0);
    idle(1);

    // WIDTH=8 wrap: 200+100 -> 44
    doReset(9);
    applyStimulus(DC, "2", 1'b1, 1'b0, 16'd2);
    applyStimulus(DC, "0", 1'b1, 1'b0, 16'd20);
    applyStimulus(DC, "0", 1'b1, 1'b0, 16'd200);
    applyStimulus(DC, "+", 1'b0, 1'b0, 16'd200);
    applyStimulus(DC, "1", 1'b1, 1'b0, 16'd201);
    applyStimulus(DC, "0", 1'b1, 1'b0, 16'd210);
    applyStimulus(DC, "0", 1'b1, 1'b0, 16'd44);
    idle(1);

    // " 2 -5" with spaces skipped: 2-5 = 0xFD in 8 bits
    doReset(10);
    applyStimulus(DC, " ", 1'b0, 1'b0, 16'd0);
    applyStimulus(DC, "2", 1'b1, 1'b0, 16'd2);
    applyStimulus(DC, " ", 1'b1, 1'b0, 16'd2);
    applyStimulus(DC, "-", 1'b0, 1'b0, 16'd2);
    applyStimulus(DC, "5", 1'b1, 1'b0, 16'h00FD);
    idle(1);

    // Same stream with spaces illegal: error from the first char
    doReset(11);
    applyStimulus(DD, " ", 1'b0, 1'b1, 16'd0);
    applyStimulus(DD, "2", 1'b0, 1'b1, 16'd0);
    applyStimulus(DD, " ", 1'b0, 1'b1, 16'd0);
    applyStimulus(DD, "-", 1'b0, 1'b1, 16'd0);
    applyStimulus(DD, "5", 1'b0, 1'b1, 16'd0);
    idle(3);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL sbDrain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
